// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - gshare branch predictor: 16-entry BTB, 16x2-bit PHT, 4-bit GHR
module branch_predict_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic        branch_taken,
   input  logic        branch_resolved,
   input  logic [3:0]  ghr_history,
   input  logic [31:0] resolved_pc,
   output logic [31:0] predicted_pc,
   output logic [3:0]  ghr_out,
   output logic        prediction_valid
);

   logic [1:0]  pht_q       [16];
   logic        btb_valid_q [16];
   logic [25:0] btb_tag_q   [16];
   logic [31:0] btb_tgt_q   [16];

   logic [3:0]  ghr_q, ghr_d;
   logic [31:0] pred_pc_q, pred_pc_d;
   logic        pred_valid_q, pred_valid_d;

   logic [3:0]  btb_idx, pht_idx, upd_idx;
   logic        hit, taken;
   logic [31:0] lookup_pc;
   logic [1:0]  pht_upd_d;

   // Lookup reads pre-update state; training lands on the same edge.
   always_comb begin
      btb_idx   = pc[5:2];
      pht_idx   = pc[5:2] ^ ghr_q;
      upd_idx   = pc[5:2] ^ ghr_history;
      hit       = btb_valid_q[btb_idx] && (btb_tag_q[btb_idx] == pc[31:6]);
      taken     = pht_q[pht_idx][1];
      lookup_pc = (hit && taken) ? btb_tgt_q[btb_idx] : pc + 32'd4;

      pht_upd_d = pht_q[upd_idx];
      if (branch_taken) begin
         if (pht_q[upd_idx] != 2'b11) pht_upd_d = pht_q[upd_idx] + 2'd1;
      end else begin
         if (pht_q[upd_idx] != 2'b00) pht_upd_d = pht_q[upd_idx] - 2'd1;
      end

      ghr_d        = ghr_q;
      pred_pc_d    = lookup_pc;
      pred_valid_d = hit && taken;
      if (branch_resolved) begin
         ghr_d        = {ghr_history[2:0], branch_taken};
         pred_pc_d    = resolved_pc;
         pred_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q        <= 4'd0;
         pred_pc_q    <= 32'd0;
         pred_valid_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            pht_q[i]       <= 2'b01;
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= 26'd0;
            btb_tgt_q[i]   <= 32'd0;
         end
      end else begin
         ghr_q        <= ghr_d;
         pred_pc_q    <= pred_pc_d;
         pred_valid_q <= pred_valid_d;
         if (branch_resolved) begin
            pht_q[upd_idx] <= pht_upd_d;
            if (branch_taken) begin
               btb_valid_q[btb_idx] <= 1'b1;
               btb_tag_q[btb_idx]   <= pc[31:6];
               btb_tgt_q[btb_idx]   <= alu_out;
            end
         end
      end
   end

   assign predicted_pc     = pred_pc_q;
   assign prediction_valid = pred_valid_q;
   assign ghr_out          = ghr_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0, alu_out = '0, resolved_pc = '0;
   logic        branch_taken = 1'b0, branch_resolved = 1'b0;
   logic [3:0]  ghr_history = '0;
   logic [31:0] predicted_pc;
   logic [3:0]  ghr_out;
   logic        prediction_valid;

   branch_predict_unit dut (
      .clk(clk), .rst(rst), .pc(pc), .alu_out(alu_out),
      .branch_taken(branch_taken), .branch_resolved(branch_resolved),
      .ghr_history(ghr_history), .resolved_pc(resolved_pc),
      .predicted_pc(predicted_pc), .ghr_out(ghr_out),
      .prediction_valid(prediction_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic        v;
      logic [3:0]  g;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   logic [1:0]  m_pht   [16];
   logic        m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   logic [3:0]  m_ghr;

   // Apply one cycle of stimulus and push what the predictor must show after the edge.
   task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] a,
                        input logic tk, input logic res, input logic [3:0] gh,
                        input logic [31:0] rp);
      exp_t e;
      logic [3:0] bi, pi, ui;
      logic h, t;
      @(negedge clk);
      rst = r; pc = p; alu_out = a; branch_taken = tk;
      branch_resolved = res; ghr_history = gh; resolved_pc = rp;
      if (r) begin
         for (int i = 0; i < 16; i++) begin
            m_pht[i] = 2'b01; m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
         end
         m_ghr = 4'd0;
         e = '0;
      end else begin
         bi = p[5:2];
         pi = bi ^ m_ghr;
         h  = m_valid[bi] && (m_tag[bi] == p[31:6]);
         t  = m_pht[pi][1];
         if (res) begin
            e.pc = rp;
            e.v  = 1'b1;
            ui = bi ^ gh;
            if (tk && m_pht[ui] != 2'b11) m_pht[ui] = m_pht[ui] + 2'd1;
            if (!tk && m_pht[ui] != 2'b00) m_pht[ui] = m_pht[ui] - 2'd1;
            if (tk) begin
               m_valid[bi] = 1'b1; m_tag[bi] = p[31:6]; m_tgt[bi] = a;
            end
            m_ghr = {gh[2:0], tk};
         end else begin
            e.pc = (h && t) ? m_tgt[bi] : p + 32'd4;
            e.v  = h && t;
         end
         e.g = m_ghr;
      end
      sb_q.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         vectors++;
         if (predicted_pc !== mon_e.pc || prediction_valid !== mon_e.v || ghr_out !== mon_e.g) begin
            miscompares++;
            $display("FAIL scoreboard: got pc=%h v=%b ghr=%b, expected pc=%h v=%b ghr=%b",
                     predicted_pc, prediction_valid, ghr_out, mon_e.pc, mon_e.v, mon_e.g);
         end
      end
   end

   task automatic test_reset();
      drive(1, 32'h4, 32'h40, 1, 1, 4'hF, 32'h40);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h0 || prediction_valid !== 1'b0 || ghr_out !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_state: got pc=%h v=%b ghr=%b, expected 0/0/0",
                  predicted_pc, prediction_valid, ghr_out);
      end
      drive(0, 32'h4, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h8 || prediction_valid !== 1'b0 || ghr_out !== 4'h0) begin
         miscompares++;
         $display("FAIL first_lookup: got pc=%h v=%b ghr=%b, expected 8/0/0",
                  predicted_pc, prediction_valid, ghr_out);
      end
   endtask

   task automatic test_train();
      drive(0, 32'h8, 32'h20, 1, 1, 4'b1010, 32'h20);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h20 || prediction_valid !== 1'b1 || ghr_out !== 4'b0101) begin
         miscompares++;
         $display("FAIL train_redirect: got pc=%h v=%b ghr=%b, expected 20/1/0101",
                  predicted_pc, prediction_valid, ghr_out);
      end
      drive(0, 32'h8, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'hC || prediction_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL weak_pht_lookup: got pc=%h v=%b, expected c/0",
                  predicted_pc, prediction_valid);
      end
   endtask

   task automatic test_predict_taken();
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 32'h8, 32'h20, 1, 1, 4'hF, 32'h20);
      drive(0, 32'h8, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h20 || prediction_valid !== 1'b1 || ghr_out !== 4'hF) begin
         miscompares++;
         $display("FAIL btb_hit_taken: got pc=%h v=%b ghr=%b, expected 20/1/1111",
                  predicted_pc, prediction_valid, ghr_out);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) drive(0, 32'h8, 32'h20, 1, 1, 4'hF, 32'h20);
      drive(0, 32'h8, 32'h0, 0, 1, 4'hF, 32'hC);
      drive(0, 32'h40, 32'h100, 1, 1, 4'hF, 32'h100);
      drive(0, 32'h8, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h20 || prediction_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL saturate_still_taken: got pc=%h v=%b, expected 20/1",
                  predicted_pc, prediction_valid);
      end
      drive(0, 32'h8, 32'h0, 0, 1, 4'hF, 32'hC);
      drive(0, 32'h40, 32'h100, 1, 1, 4'hF, 32'h100);
      drive(0, 32'h8, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'hC || prediction_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL decrement_to_not_taken: got pc=%h v=%b, expected c/0",
                  predicted_pc, prediction_valid);
      end
   endtask

   task automatic test_not_taken();
      drive(0, 32'hC, 32'h0, 0, 1, 4'b1100, 32'h10);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h10 || prediction_valid !== 1'b1 || ghr_out !== 4'b1000) begin
         miscompares++;
         $display("FAIL not_taken_redirect: got pc=%h v=%b ghr=%b, expected 10/1/1000",
                  predicted_pc, prediction_valid, ghr_out);
      end
   endtask

   task automatic test_wrap_and_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h0 || prediction_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL pc_wrap: got pc=%h v=%b, expected 0/0", predicted_pc, prediction_valid);
      end
      drive(0, 32'h8, 32'h20, 1, 1, 4'h0, 32'h20);
      drive(0, 32'h8, 32'h20, 1, 1, 4'h0, 32'h20);
      drive(1, 32'h8, 32'h20, 1, 1, 4'h0, 32'h20);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'h0 || prediction_valid !== 1'b0 || ghr_out !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_during_resolve: got pc=%h v=%b ghr=%b, expected 0/0/0",
                  predicted_pc, prediction_valid, ghr_out);
      end
      drive(0, 32'h8, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      vectors++;
      if (predicted_pc !== 32'hC || prediction_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL tables_cleared: got pc=%h v=%b, expected c/0",
                  predicted_pc, prediction_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [5];
      pcs[0] = 32'h8; pcs[1] = 32'hC; pcs[2] = 32'h40; pcs[3] = 32'h48; pcs[4] = 32'h1008;
      for (int i = 0; i < 80; i++) begin
         drive(($urandom_range(0, 29) == 0), pcs[$urandom_range(0, 4)],
               {$urandom_range(0, 255), 2'b00}, 1'($urandom), 1'($urandom),
               4'($urandom), {$urandom_range(0, 255), 2'b00});
      end
      drive(0, 32'h8, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_train();
      test_predict_taken();
      test_saturate();
      test_not_taken();
      test_wrap_and_reset();
      test_back_to_back();
      @(posedge clk); #3;
      @(posedge clk); #3;
      vectors++;
      if (sb_q.size() !== 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
